// File: rtl/ysyx_220066_dmem_pkg.sv
// ============================================================================
// Module      : ysyx_220066_dmem_pkg
// Description : MemOp encodings, responder FSM states and strobe helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_220066_dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_D  = 3'b011;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;
    localparam logic [2:0] MOP_WU = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Lane-0 byte strobe for an access size (MemOp[1:0]).
    function automatic logic [7:0] size_strb(input logic [1:0] sz);
        case (sz)
            2'b00:   size_strb = 8'h01;
            2'b01:   size_strb = 8'h03;
            2'b10:   size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_220066_dmem_lane.sv
// ============================================================================
// Module      : ysyx_220066_dmem_lane
// Description : Byte-lane steering: store strobe/merge, load extension, misalign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_220066_dmem_lane
    import ysyx_220066_dmem_pkg::*;
(
    input  logic [2:0]  i_mem_op,
    input  logic [2:0]  i_lane,
    input  logic [63:0] i_old_word,
    input  logic [63:0] i_wr_data,
    output logic [7:0]  o_strb,
    output logic [63:0] o_wr_word,
    output logic [63:0] o_rd_data,
    output logic        o_misalign
);

    logic [5:0]  w_shamt;
    logic [63:0] w_wr_shift;
    logic [63:0] w_rd_shift;

    assign w_shamt    = {i_lane, 3'b000};
    assign w_wr_shift = i_wr_data << w_shamt;
    assign w_rd_shift = i_old_word >> w_shamt;
    assign o_strb     = size_strb(i_mem_op[1:0]) << i_lane;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_byte
            assign o_wr_word[8*g +: 8] = o_strb[g] ? w_wr_shift[8*g +: 8]
                                                  : i_old_word[8*g +: 8];
        end
    endgenerate

    always_comb begin
        o_rd_data = w_rd_shift;
        case (i_mem_op)
            MOP_B:   o_rd_data = {{56{w_rd_shift[7]}},  w_rd_shift[7:0]};
            MOP_H:   o_rd_data = {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
            MOP_W:   o_rd_data = {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
            MOP_BU:  o_rd_data = {56'd0, w_rd_shift[7:0]};
            MOP_HU:  o_rd_data = {48'd0, w_rd_shift[15:0]};
            MOP_WU:  o_rd_data = {32'd0, w_rd_shift[31:0]};
            default: o_rd_data = w_rd_shift;
        endcase
    end

    always_comb begin
        case (i_mem_op[1:0])
            2'b01:   o_misalign = i_lane[0];
            2'b10:   o_misalign = |i_lane[1:0];
            2'b11:   o_misalign = |i_lane;
            default: o_misalign = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_220066_dmem.sv
// ============================================================================
// Module      : ysyx_220066_dmem
// Description : Fixed-latency data-memory responder with byte lanes and errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_220066_dmem
    import ysyx_220066_dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [63:0] addr,
    input  logic [63:0] data_Wr,
    output logic [63:0] data_Rd,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int         c_WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_rd, r_wr;
    logic [2:0]  r_op;
    logic [63:0] r_addr, r_wdata;
    logic [63:0] r_data_rd;
    logic        r_error;
    logic [63:0] r_mem [c_WORDS];

    logic        w_idle, w_enter_resp, w_err, w_in_range, w_misalign;
    logic        w_req_rd, w_req_wr;
    logic [2:0]  w_req_op;
    logic [63:0] w_req_addr, w_req_wdata, w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [63:0] w_old_word, w_wr_word, w_rd_data;
    logic [7:0]  w_strb;
    logic        w_unused_ok;

    // With LATENCY==1 the array acts on the accept edge, before capture lands.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_req_rd    = w_idle ? MemRd   : r_rd;
    assign w_req_wr    = w_idle ? MemWr   : r_wr;
    assign w_req_op    = w_idle ? MemOp   : r_op;
    assign w_req_addr  = w_idle ? addr    : r_addr;
    assign w_req_wdata = w_idle ? data_Wr : r_wdata;

    assign w_off       = w_req_addr - BASE;
    assign w_in_range  = (w_req_addr >= BASE) && (w_off[63:DEPTH_LOG2+3] == '0);
    assign w_idx       = w_off[DEPTH_LOG2+2:3];
    assign w_old_word  = r_mem[w_idx];
    assign w_unused_ok = &{1'b0, w_off[2:0], w_strb};

    ysyx_220066_dmem_lane u_lane (
        .i_mem_op   (w_req_op),
        .i_lane     (w_req_addr[2:0]),
        .i_old_word (w_old_word),
        .i_wr_data  (w_req_wdata),
        .o_strb     (w_strb),
        .o_wr_word  (w_wr_word),
        .o_rd_data  (w_rd_data),
        .o_misalign (w_misalign)
    );

    assign w_err = (w_req_rd & w_req_wr) | w_misalign | ~w_in_range
                 | (w_req_rd & (w_req_op == 3'b111)) | (w_req_wr & w_req_op[2]);

    assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (MemRd | MemWr) w_next = (LATENCY > 1) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = (r_state == ST_RESP);
        busy    = (r_state == ST_WAIT);
        error   = r_error;
        data_Rd = r_data_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data_rd <= '0;
            r_error   <= 1'b0;
        end else begin
            if (w_idle && (MemRd || MemWr)) begin
                r_rd    <= MemRd;
                r_wr    <= MemWr;
                r_op    <= MemOp;
                r_addr  <= addr;
                r_wdata <= data_Wr;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_error   <= w_err;
                r_data_rd <= (w_err || w_req_wr) ? 64'd0 : w_rd_data;
            end
        end
    end

    // Array is not reset; reset holds the FSM in IDLE so an in-flight write never lands.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_req_wr && !w_err)
            r_mem[w_idx] <= w_wr_word;
    end

endmodule

`default_nettype wire
